fp_wb_tracker: RTL and testbench
================================

Name: fp_wb_tracker

Overview:
Consumer-side controller for the multi-cycle floating-point execute path.
- Accepts FP operation issues from decode/issue.
- Tracks the single outstanding multi-cycle op with a latency counter.
- Asserts a pipeline stall while the op is in flight.
- Samples the FP unit result on the exact completion edge and presents a one-cycle registered writeback to the F register file.

It replaces the free-running stall counter as the authority for FP stall and writeback timing.

Parameters:
LAT_FADD, 7, cycles from issue to result for fadd/fsub (op 4'b1011, 4'b1100)
LAT_FMUL, 6, cycles for fmul (op 4'b1101)
LAT_FDIV, 6, cycles for fdiv (op 4'b1110)
RD_W, 5, destination register index width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
issue_valid  input  1  FP op presented this cycle
issue_op  input  4  FP opcode (EX[4:1] encoding)
issue_rd  input  RD_W  destination F register
issue_ready  output  1  tracker can accept an issue this cycle
stall  output  1  high while a multi-cycle op is in flight; freezes upstream stages
flush  input  1  cancel any in-flight op (branch/exception)
fu_result  input  32  FP unit result bus
fu_dbz  input  1  divide-by-zero flag from the divider
wb_valid  output  1  registered writeback strobe, one cycle per op
wb_rd  output  RD_W  writeback destination
wb_data  output  32  writeback data
wb_exc  output  1  divide-by-zero exception accompanying wb_valid
bad_op  output  1  one-cycle pulse: unsupported opcode was presented

Behaviour:
Clock and reset:
- clk is the clock. rst is synchronous and active-high.
- On reset: state = IDLE, cnt = 0, stall = 0, wb_valid = 0, wb_exc = 0, bad_op = 0, wb_rd = 0, wb_data = 0. issue_ready = 1 after reset.
- Reset mid-operation drops the in-flight op with no writeback.

States:
- IDLE: no op pending.
- WAIT: multi-cycle op in flight.
- WRITE: wb_valid high.

Acceptance:
- An issue is accepted at an edge where issue_valid & issue_ready & ~flush.
- issue_ready = (state != WAIT) combinationally.
- stall = (state == WAIT), registered state decode.

Latency by opcode:
- fneg 4'b1010: L = 0.
- fadd/fsub: L = LAT_FADD.
- fmul: L = LAT_FMUL.
- fdiv: L = LAT_FDIV.
- itof 4'b1000 and ftoi 4'b1001 are unsupported: no tracking; bad_op pulses for the following cycle; state is unchanged.

Accept at edge T with L = 0:
- fu_result is captured into wb_data at edge T; wb_exc = 0.
- state goes to WRITE.

Accept at edge T with L ≥ 1:
- cnt <= L, rd is latched, state goes to WAIT.
- In WAIT, each edge with cnt > 1 decrements cnt.
- At the edge where cnt == 1 (edge T+L): wb_data <= fu_result, wb_exc <= fu_dbz (fdiv only, else 0), state goes to WRITE.

WRITE:
- wb_valid = 1, wb_rd = latched rd, for exactly one cycle.
- Next edge: a new accept is legal (back-to-back) and proceeds per the acceptance rules; otherwise state returns to IDLE.
- wb_valid is low in all other states.

Flush:
- flush in WAIT: next edge forces IDLE, cnt = 0, no writeback.
- flush in WRITE does not suppress the writeback already in progress, but blocks the same-edge accept.
- flush has priority over completion when both occur on the same edge.

Other rules:
- issue_valid in WAIT is ignored; upstream must hold the op because stall is high.
- wb_data and wb_rd hold their last values when wb_valid = 0.

Test Plan:
- Reset: rst high for 2 cycles -> stall = 0, wb_valid = 0, issue_ready = 1, wb_data = 0.
- fadd rd=3 accepted at edge 10, fu_result = 32'h40400000 held stable -> stall high for cycles after edges 10..16; wb_valid = 1 with wb_rd = 3, wb_data = 32'h40400000 only in the cycle after edge 17; stall = 0 in that cycle.
- fneg rd=1 at edge 5, fu_result = 32'hBF800000 -> wb_valid in the cycle after edge 5 only, stall never asserts. Then fmul rd=2 accepted at edge 6 -> wb after edge 12.
- fdiv rd=7 with fu_dbz = 1 at completion edge -> wb_valid = 1, wb_exc = 1, wb_rd = 7, six cycles after accept.
- fmul accepted, flush asserted 3 cycles later -> stall drops after the flush edge, no wb_valid ever; the next issue is accepted immediately.
- itof presented in IDLE -> bad_op pulses for 1 cycle, stall = 0, no wb_valid. rst asserted mid-WAIT -> IDLE next edge, no writeback.

Source files
------------

// File: rtl/fp_wb_tracker.sv
// fp_wb_tracker: consumer-side controller for the multi-cycle FP execute path.
// Tracks one outstanding FP op, stalls the pipeline while it is in flight,
// samples the FP unit result on the completion edge and presents a
// one-cycle registered writeback to the F register file.
module fp_wb_tracker #(
    parameter int LAT_FADD = 7,
    parameter int LAT_FMUL = 6,
    parameter int LAT_FDIV = 6,
    parameter int RD_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [3:0]      issue_op,
    input  logic [RD_W-1:0] issue_rd,
    output logic            issue_ready,
    output logic            stall,
    input  logic            flush,
    input  logic [31:0]     fu_result,
    input  logic            fu_dbz,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_exc,
    output logic            bad_op
);

    localparam int CNT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    // Opcodes in the EX[4:1] encoding
    localparam logic [3:0] OP_ITOF = 4'b1000;
    localparam logic [3:0] OP_FTOI = 4'b1001;
    localparam logic [3:0] OP_FNEG = 4'b1010;
    localparam logic [3:0] OP_FADD = 4'b1011;
    localparam logic [3:0] OP_FSUB = 4'b1100;
    localparam logic [3:0] OP_FMUL = 4'b1101;
    localparam logic [3:0] OP_FDIV = 4'b1110;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RD_W-1:0]  r_rd;
    logic             r_is_div;
    logic [RD_W-1:0]  r_wb_rd;
    logic [31:0]      r_wb_data;
    logic             r_wb_exc;
    logic             r_bad_op;

    logic             w_ready;
    logic             w_accept;
    logic             w_supported;
    logic             w_is_div;
    logic [CNT_W-1:0] w_lat;

    assign w_ready  = (r_state != S_WAIT);
    assign w_accept = issue_valid & w_ready & ~flush;

    // Opcode decode: latency, divider flag and whether the op is tracked at all
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_supported = 1'b0;
        w_is_div    = 1'b0;
        w_lat       = '0;
        case (issue_op)
            OP_FNEG: begin
                w_supported = 1'b1;
            end
            OP_FADD, OP_FSUB: begin
                w_supported = 1'b1;
                w_lat       = CNT_W'(LAT_FADD);
            end
            OP_FMUL: begin
                w_supported = 1'b1;
                w_lat       = CNT_W'(LAT_FMUL);
            end
            OP_FDIV: begin
                w_supported = 1'b1;
                w_is_div    = 1'b1;
                w_lat       = CNT_W'(LAT_FDIV);
            end
            OP_ITOF, OP_FTOI: begin
                w_supported = 1'b0;
            end
            default: begin
                w_supported = 1'b0;
            end
        endcase
    end

    // Tracker state, latency counter and registered writeback payload
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_is_div  <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_exc  <= 1'b0;
            r_bad_op  <= 1'b0;
        end else begin
            r_bad_op <= w_accept & ~w_supported;
            case (r_state)
                S_IDLE, S_WRITE: begin
                    if (w_accept && w_supported) begin
                        if (w_lat == '0) begin
                            // Zero-latency op: result is already on the bus
                            r_wb_data <= fu_result;
                            r_wb_exc  <= 1'b0;
                            r_wb_rd   <= issue_rd;
                            r_state   <= S_WRITE;
                        end else begin
                            r_cnt    <= w_lat;
                            r_rd     <= issue_rd;
                            r_is_div <= w_is_div;
                            r_state  <= S_WAIT;
                        end
                    end else begin
                        // Unsupported ops and idle cycles leave nothing pending
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        // Flush wins over a same-edge completion
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_wb_data <= fu_result;
                        r_wb_exc  <= r_is_div & fu_dbz;
                        r_wb_rd   <= r_rd;
                        r_cnt     <= '0;
                        r_state   <= S_WRITE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign issue_ready = w_ready;
    assign stall       = (r_state == S_WAIT);
    assign wb_valid    = (r_state == S_WRITE);
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign wb_exc      = r_wb_exc & wb_valid;
    assign bad_op      = r_bad_op;

endmodule

// File: tb/tb_fp_wb_tracker.sv
// tb_fp_wb_tracker: directed-vector bench for fp_wb_tracker.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising (active) edge.
module tb_fp_wb_tracker;

    localparam int RD_W = 5;

    logic            clk;
    logic            rst;
    logic            issue_valid;
    logic [3:0]      issue_op;
    logic [RD_W-1:0] issue_rd;
    logic            issue_ready;
    logic            stall;
    logic            flush;
    logic [31:0]     fu_result;
    logic            fu_dbz;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            wb_exc;
    logic            bad_op;

    int errors = 0;
    int checks = 0;

    fp_wb_tracker #(
        .LAT_FADD(7), .LAT_FMUL(6), .LAT_FDIV(6), .RD_W(RD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_op   (issue_op),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .stall      (stall),
        .flush      (flush),
        .fu_result  (fu_result),
        .fu_dbz     (fu_dbz),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_exc     (wb_exc),
        .bad_op     (bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance over one rising edge and stop at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [3:0] op, input logic [RD_W-1:0] rd);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
    endtask

    task automatic idle_issue();
        issue_valid = 1'b0;
        issue_op    = 4'b0000;
        issue_rd    = '0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fu_result = 32'h0;
        fu_dbz = 1'b0;
        idle_issue();

        // Reset state
        @(negedge clk);
        step();
        step();
        check("rst_stall", stall, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_ready", issue_ready, 1);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_exc", wb_exc, 0);
        check("rst_bad_op", bad_op, 0);
        rst = 1'b0;
        step();

        // fadd rd=3: stall after accept edge and the six following edges, wb after the 7th
        fu_result = 32'h40400000;
        present(4'b1011, 5'd3);
        step();
        idle_issue();
        check("fadd_stall_0", stall, 1);
        check("fadd_ready_0", issue_ready, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("fadd_stall_%0d", i), stall, 1);
            check($sformatf("fadd_nowb_%0d", i), wb_valid, 0);
        end
        step();
        check("fadd_wb_valid", wb_valid, 1);
        check("fadd_wb_rd", wb_rd, 3);
        check("fadd_wb_data", wb_data, 32'h40400000);
        check("fadd_wb_stall", stall, 0);
        check("fadd_wb_exc", wb_exc, 0);
        step();
        check("fadd_wb_done", wb_valid, 0);
        check("fadd_data_hold", wb_data, 32'h40400000);

        // fneg rd=1: zero latency, then fmul rd=2 back-to-back from WRITE
        fu_result = 32'hBF800000;
        present(4'b1010, 5'd1);
        step();
        check("fneg_wb_valid", wb_valid, 1);
        check("fneg_wb_rd", wb_rd, 1);
        check("fneg_wb_data", wb_data, 32'hBF800000);
        check("fneg_stall", stall, 0);
        fu_result = 32'h40000000;
        fu_dbz = 1'b1;
        present(4'b1101, 5'd2);
        step();
        idle_issue();
        check("fmul_stall_0", stall, 1);
        check("fmul_nowb_0", wb_valid, 0);
        check("fmul_rd_hold", wb_rd, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("fmul_stall_%0d", i), stall, 1);
        end
        step();
        check("fmul_wb_valid", wb_valid, 1);
        check("fmul_wb_rd", wb_rd, 2);
        check("fmul_wb_data", wb_data, 32'h40000000);
        check("fmul_wb_exc", wb_exc, 0);
        fu_dbz = 1'b0;
        step();

        // fdiv rd=7 with divide-by-zero flagged on the completion edge
        fu_result = 32'h7F800000;
        present(4'b1110, 5'd7);
        step();
        idle_issue();
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("fdiv_nowb_%0d", i), wb_valid, 0);
        end
        fu_dbz = 1'b1;
        step();
        check("fdiv_wb_valid", wb_valid, 1);
        check("fdiv_wb_exc", wb_exc, 1);
        check("fdiv_wb_rd", wb_rd, 7);
        check("fdiv_wb_data", wb_data, 32'h7F800000);
        fu_dbz = 1'b0;
        step();
        check("fdiv_exc_clr", wb_exc, 0);

        // fmul flushed three cycles after accept: no writeback ever
        present(4'b1101, 5'd9);
        step();
        idle_issue();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_stall", stall, 0);
        check("flush_ready", issue_ready, 1);
        check("flush_nowb", wb_valid, 0);
        // Next issue is accepted straight away
        fu_result = 32'h3F800000;
        present(4'b1010, 5'd4);
        step();
        check("post_flush_wb", wb_valid, 1);
        check("post_flush_rd", wb_rd, 4);
        // Flush in WRITE blocks the same-edge accept
        flush = 1'b1;
        present(4'b1010, 5'd5);
        step();
        flush = 1'b0;
        idle_issue();
        check("flush_write_block", wb_valid, 0);
        check("flush_write_rd", wb_rd, 4);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("flush_quiet_%0d", i), wb_valid, 0);
        end

        // Unsupported itof in IDLE
        present(4'b1000, 5'd6);
        step();
        idle_issue();
        check("itof_bad_op", bad_op, 1);
        check("itof_stall", stall, 0);
        check("itof_nowb", wb_valid, 0);
        step();
        check("itof_bad_clr", bad_op, 0);
        check("itof_nowb2", wb_valid, 0);

        // Reset in the middle of WAIT drops the op
        present(4'b1011, 5'd8);
        step();
        idle_issue();
        step();
        check("rstw_stall_pre", stall, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw_stall", stall, 0);
        check("rstw_ready", issue_ready, 1);
        check("rstw_data", wb_data, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rstw_nowb_%0d", i), wb_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
